// File: rtl/alu_stim_gen.sv
// Seedable random (A, B, op) transaction source for the serial ALU environment.
// Operands come from two DATA_W-bit Galois LFSRs, while a 16-bit LFSR_C supplies
// the corner selects and raw op codes. Each accepted transaction advances all
// three LFSRs by exactly one step.
module alu_stim_gen #(
    parameter int unsigned DATA_W    = 32,
    parameter logic [31:0] SEED      = 32'hACE1_2021,
    parameter int unsigned CNT_W     = 16,
    parameter bit          CORNER_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              seed_load,
    input  logic [31:0]       seed_in,
    input  logic [7:0]        op_mask,
    input  logic [CNT_W-1:0]  num_trans,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic [2:0]        op_o,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  count
);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    function automatic logic [63:0] tp(input int unsigned t);
        return 64'd1 << (t - 1);
    endfunction

    // Maximal-length Galois feedback masks (right-shifting form), indexed by width.
    function automatic logic [63:0] poly_mask(input int unsigned w);
        case (w)
            8:  return tp(8)  | tp(6)  | tp(5)  | tp(4);
            9:  return tp(9)  | tp(5);
            10: return tp(10) | tp(7);
            11: return tp(11) | tp(9);
            12: return tp(12) | tp(6)  | tp(4)  | tp(1);
            13: return tp(13) | tp(4)  | tp(3)  | tp(1);
            14: return tp(14) | tp(5)  | tp(3)  | tp(1);
            15: return tp(15) | tp(14);
            16: return tp(16) | tp(15) | tp(13) | tp(4);
            17: return tp(17) | tp(14);
            18: return tp(18) | tp(11);
            19: return tp(19) | tp(6)  | tp(2)  | tp(1);
            20: return tp(20) | tp(17);
            21: return tp(21) | tp(19);
            22: return tp(22) | tp(21);
            23: return tp(23) | tp(18);
            24: return tp(24) | tp(23) | tp(22) | tp(17);
            25: return tp(25) | tp(22);
            26: return tp(26) | tp(6)  | tp(2)  | tp(1);
            27: return tp(27) | tp(5)  | tp(2)  | tp(1);
            28: return tp(28) | tp(25);
            29: return tp(29) | tp(27);
            30: return tp(30) | tp(6)  | tp(4)  | tp(1);
            31: return tp(31) | tp(28);
            33: return tp(33) | tp(20);
            34: return tp(34) | tp(27) | tp(2)  | tp(1);
            35: return tp(35) | tp(33);
            36: return tp(36) | tp(25);
            37: return tp(37) | tp(5)  | tp(4)  | tp(3) | tp(2) | tp(1);
            38: return tp(38) | tp(6)  | tp(5)  | tp(1);
            39: return tp(39) | tp(35);
            40: return tp(40) | tp(38) | tp(21) | tp(19);
            41: return tp(41) | tp(38);
            42: return tp(42) | tp(41) | tp(20) | tp(19);
            43: return tp(43) | tp(42) | tp(38) | tp(37);
            44: return tp(44) | tp(43) | tp(18) | tp(17);
            45: return tp(45) | tp(44) | tp(42) | tp(41);
            46: return tp(46) | tp(45) | tp(26) | tp(25);
            47: return tp(47) | tp(42);
            48: return tp(48) | tp(47) | tp(21) | tp(20);
            49: return tp(49) | tp(40);
            50: return tp(50) | tp(49) | tp(24) | tp(23);
            51: return tp(51) | tp(50) | tp(36) | tp(35);
            52: return tp(52) | tp(49);
            53: return tp(53) | tp(52) | tp(38) | tp(37);
            54: return tp(54) | tp(53) | tp(18) | tp(17);
            55: return tp(55) | tp(31);
            56: return tp(56) | tp(55) | tp(35) | tp(34);
            57: return tp(57) | tp(50);
            58: return tp(58) | tp(39);
            59: return tp(59) | tp(58) | tp(38) | tp(37);
            60: return tp(60) | tp(59);
            61: return tp(61) | tp(60) | tp(46) | tp(45);
            62: return tp(62) | tp(61) | tp(6)  | tp(5);
            63: return tp(63) | tp(62);
            64: return tp(64) | tp(63) | tp(61) | tp(60);
            default: return tp(32) | tp(22) | tp(2) | tp(1);
        endcase
    endfunction

    localparam logic [63:0]       POLY_W = poly_mask(DATA_W);
    localparam logic [DATA_W-1:0] POLY_A = POLY_W[DATA_W-1:0];
    localparam logic [15:0]       POLY_C = 16'hB400;

    function automatic logic [DATA_W-1:0] step_w(input logic [DATA_W-1:0] x);
        return x[0] ? ((x >> 1) ^ POLY_A) : (x >> 1);
    endfunction

    function automatic logic [15:0] step_c(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ POLY_C) : (x >> 1);
    endfunction

    // All-zero is the lock-up state of an XOR LFSR, so it is replaced by 1.
    function automatic logic [DATA_W-1:0] nz(input logic [DATA_W-1:0] x);
        return (x == '0) ? DATA_W'(1) : x;
    endfunction

    function automatic logic [DATA_W-1:0] corner(input logic [1:0] sel,
                                                 input logic [DATA_W-1:0] v);
        if (CORNER_EN && sel == 2'b00) return '0;
        if (CORNER_EN && sel == 2'b11) return '1;
        return v;
    endfunction

    // The first enabled code at or above raw, wrapping from 7 back to 0.
    function automatic logic [2:0] pick_op(input logic [2:0] raw, input logic [7:0] m);
        logic [2:0] idx;
        logic       found;
        pick_op = raw;
        found   = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = raw + 3'(i);
            if (!found && m[idx]) begin
                pick_op = idx;
                found   = 1'b1;
            end
        end
    endfunction

    state_t             state, state_n;
    logic [DATA_W-1:0]  lfsr_a, lfsr_b, lfsr_a_n, lfsr_b_n, src_a, src_b;
    logic [15:0]        lfsr_c, lfsr_c_n, src_c;
    logic [CNT_W-1:0]   num_lat, num_lat_n, count_n, cnt_inc;
    logic [7:0]         mask_lat, mask_lat_n, gen_mask;
    logic [DATA_W-1:0]  a_n, b_n;
    logic [2:0]         op_n;
    logic               valid_n, done_n, err_n, gen;

    assign busy    = (state == SEND);
    assign cnt_inc = (&count) ? count : count + CNT_W'(1);

    // Next-state, LFSR stepping and output generation.
    always_comb begin
        state_n    = state;
        lfsr_a_n   = lfsr_a;
        lfsr_b_n   = lfsr_b;
        lfsr_c_n   = lfsr_c;
        num_lat_n  = num_lat;
        mask_lat_n = mask_lat;
        count_n    = count;
        valid_n    = valid_o;
        done_n     = done;
        err_n      = err;
        a_n        = a_o;
        b_n        = b_o;
        op_n       = op_o;
        src_a      = lfsr_a;
        src_b      = lfsr_b;
        src_c      = lfsr_c;
        gen_mask   = mask_lat;
        gen        = 1'b0;

        if (abort) begin
            state_n = IDLE;
            valid_n = 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    // A seed loaded together with start feeds the first generate.
                    if (seed_load) begin
                        src_a    = nz(DATA_W'(seed_in));
                        src_b    = nz(~DATA_W'(seed_in));
                        src_c    = seed_in[15:0] | 16'd1;
                        lfsr_a_n = src_a;
                        lfsr_b_n = src_b;
                        lfsr_c_n = src_c;
                    end
                    if (start) begin
                        if (op_mask == 8'd0) begin
                            err_n = 1'b1;
                        end else if (num_trans == '0) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                            count_n = '0;
                        end else begin
                            state_n    = SEND;
                            done_n     = 1'b0;
                            err_n      = 1'b0;
                            count_n    = '0;
                            num_lat_n  = num_trans;
                            mask_lat_n = op_mask;
                            gen_mask   = op_mask;
                            valid_n    = 1'b1;
                            gen        = 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (valid_o && ready_i) begin
                        count_n = cnt_inc;
                        if (cnt_inc == num_lat) begin
                            state_n = DONE;
                            valid_n = 1'b0;
                            done_n  = 1'b1;
                        end else begin
                            gen = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        if (gen) begin
            lfsr_a_n = step_w(src_a);
            lfsr_b_n = step_w(src_b);
            lfsr_c_n = step_c(src_c);
            a_n      = corner(lfsr_c_n[1:0], lfsr_a_n);
            b_n      = corner(lfsr_c_n[3:2], lfsr_b_n);
            op_n     = pick_op(lfsr_c_n[6:4], gen_mask);
        end
    end

    // State, LFSR and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lfsr_a   <= nz(DATA_W'(SEED));
            lfsr_b   <= nz(~DATA_W'(SEED));
            lfsr_c   <= SEED[15:0] | 16'd1;
            num_lat  <= '0;
            mask_lat <= '0;
            count    <= '0;
            valid_o  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            a_o      <= '0;
            b_o      <= '0;
            op_o     <= '0;
        end else begin
            state    <= state_n;
            lfsr_a   <= lfsr_a_n;
            lfsr_b   <= lfsr_b_n;
            lfsr_c   <= lfsr_c_n;
            num_lat  <= num_lat_n;
            mask_lat <= mask_lat_n;
            count    <= count_n;
            valid_o  <= valid_n;
            done     <= done_n;
            err      <= err_n;
            a_o      <= a_n;
            b_o      <= b_n;
            op_o     <= op_n;
        end
    end

endmodule

// File: tb/tb_alu_stim_gen.sv
// Bench for alu_stim_gen: a reference LFSR model pushes expected transactions
// into a queue, and every handshake pops one entry and compares against it.
module tb_alu_stim_gen;

    localparam logic [31:0] SEED   = 32'hACE1_2021;
    localparam logic [31:0] POLY32 = 32'h8020_0003;   // taps 32,22,2,1
    localparam logic [15:0] POLYC  = 16'hB400;

    logic        clk, rst_n, start, abort, seed_load, ready_i;
    logic [31:0] seed_in;
    logic [7:0]  op_mask;
    logic [15:0] num_trans;
    logic        valid_o, busy, done, err;
    logic [31:0] a_o, b_o;
    logic [2:0]  op_o;
    logic [15:0] count;

    // Second instance: 64-bit, no corner weighting.
    logic        start2, valid2, busy2, done2, err2;
    logic [63:0] a2, b2;
    logic [2:0]  op2;
    logic [15:0] count2;

    alu_stim_gen #(.DATA_W(32), .SEED(SEED), .CNT_W(16), .CORNER_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed_load(seed_load),
        .seed_in(seed_in), .op_mask(op_mask), .num_trans(num_trans), .valid_o(valid_o),
        .ready_i(ready_i), .a_o(a_o), .b_o(b_o), .op_o(op_o), .busy(busy), .done(done),
        .err(err), .count(count)
    );

    alu_stim_gen #(.DATA_W(64), .SEED(SEED), .CNT_W(16), .CORNER_EN(1'b0)) u_dut_nc (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0), .seed_load(1'b0),
        .seed_in(32'd0), .op_mask(8'hFF), .num_trans(16'd1024), .valid_o(valid2),
        .ready_i(1'b1), .a_o(a2), .b_o(b2), .op_o(op2), .busy(busy2), .done(done2),
        .err(err2), .count(count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] ma, mb;
    logic [15:0] mc;
    int          z_cnt, o_cnt;

    task automatic model_seed(input logic [31:0] s);
        ma = (s == 32'd0) ? 32'd1 : s;
        mb = (~s == 32'd0) ? 32'd1 : ~s;
        mc = s[15:0] | 16'd1;
    endtask

    function automatic logic [31:0] m_corner(input logic [1:0] sel, input logic [31:0] v);
        if (sel == 2'b00) return 32'd0;
        if (sel == 2'b11) return 32'hFFFF_FFFF;
        return v;
    endfunction

    task automatic push_exp(input logic [7:0] m);
        txn_t t;
        int   r;
        ma = ma[0] ? ((ma >> 1) ^ POLY32) : (ma >> 1);
        mb = mb[0] ? ((mb >> 1) ^ POLY32) : (mb >> 1);
        mc = mc[0] ? ((mc >> 1) ^ POLYC) : (mc >> 1);
        t.a  = m_corner(mc[1:0], ma);
        t.b  = m_corner(mc[3:2], mb);
        r    = int'(mc[6:4]);
        t.op = 3'(r);
        for (int k = 7; k >= 0; k--)
            if (m[(r + k) % 8]) t.op = 3'((r + k) % 8);
        exp_q.push_back(t);
    endtask

    // Start a run at the current falling edge and score it to completion.
    task automatic run_txn(input int n, input logic [7:0] m, input int stall_at,
                           input int stall_len, input int abort_at);
        int   hs, stalled, cyc, vcyc;
        txn_t t;
        hs = 0; stalled = 0; cyc = 0; vcyc = 0;
        start = 1'b1; op_mask = m; num_trans = 16'(n); ready_i = 1'b1;
        push_exp(m);
        @(negedge clk);
        start = 1'b0; seed_load = 1'b0;
        op_mask = ~m; num_trans = 16'(n / 2);     // must not affect a latched run
        check("latency_valid", valid_o, 1);
        check("run_busy", busy, 1);
        check("run_err_clear", err, 0);
        while (hs < n && cyc < n * 2 + stall_len + 16) begin
            if (hs == stall_at && stalled < stall_len) begin
                ready_i = 1'b0; stalled++;
            end else begin
                ready_i = 1'b1;
            end
            if (hs == abort_at) abort = 1'b1;
            check("valid_cont", valid_o, 1);
            if (valid_o) begin
                vcyc++;
                check("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    t = exp_q[0];
                    check("a_o", a_o, t.a);
                    check("b_o", b_o, t.b);
                    check("op_o", op_o, t.op);
                end
            end
            if (abort) begin
                @(negedge clk);
                abort = 1'b0;
                check("abort_valid", valid_o, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_count", count, 64'(abort_at));
                exp_q.delete();
                return;
            end
            if (valid_o && ready_i) begin
                hs++;
                if (a_o == 32'd0) z_cnt++;
                if (a_o == 32'hFFFF_FFFF) o_cnt++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                if (hs < n) push_exp(m);
            end
            @(negedge clk);
            cyc++;
        end
        check("hs_total", hs, 64'(n));
        check("valid_cycles", vcyc, 64'(n + stall_len));
        check("end_valid", valid_o, 0);
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_count", count, 64'(n));
        check("sb_drained", exp_q.size(), 0);
    endtask

    task automatic load_seed(input logic [31:0] s);
        seed_in = s; seed_load = 1'b1;
        model_seed(s);
        @(negedge clk);
        seed_load = 1'b0;
    endtask

    initial begin
        int nc_z, nc_o, cyc;
        logic [7:0] ops_seen;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; seed_load = 1'b0; ready_i = 1'b1;
        seed_in = '0; op_mask = 8'hFF; num_trans = '0; start2 = 1'b0;
        z_cnt = 0; o_cnt = 0;
        repeat (2) @(negedge clk);
        check("rst_valid", valid_o, 0);
        check("rst_a", a_o, 0);
        check("rst_b", b_o, 0);
        check("rst_op", op_o, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_count", count, 0);
        rst_n = 1'b1;
        model_seed(SEED);
        @(negedge clk);

        // Basic run, then the same stream again with a 3-cycle stall on transaction 2.
        run_txn(4, 8'hFF, -1, 0, -1);
        load_seed(SEED);
        run_txn(4, 8'hFF, 1, 3, -1);

        // Single enabled op.
        run_txn(1000, 8'b0000_0100, -1, 0, -1);

        // Empty mask: sticky err, nothing emitted.
        op_mask = 8'h00; num_trans = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_set", err, 1);
        for (int i = 0; i < 3; i++) begin
            check("err_no_valid", valid_o, 0);
            @(negedge clk);
        end
        check("err_sticky", err, 1);

        // Zero seed loaded together with start, then reproducible explicit seeds.
        seed_in = 32'd0; seed_load = 1'b1; model_seed(32'd0);
        run_txn(8, 8'hFF, -1, 0, -1);
        load_seed(32'h1234_5678);
        run_txn(8, 8'h5A, -1, 0, -1);
        load_seed(32'h1234_5678);
        run_txn(8, 8'h5A, 2, 2, -1);

        // Zero-length run.
        op_mask = 8'hFF; num_trans = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero_done", done, 1);
        check("zero_count", count, 0);
        check("zero_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            check("zero_no_valid", valid_o, 0);
            @(negedge clk);
        end

        // Abort on transaction 3 of 10; the model keeps the LFSR state it reached.
        run_txn(10, 8'hFF, -1, 0, 2);

        // Corner weighting over 4096 operands: ~25% zero, ~25% all-ones.
        z_cnt = 0; o_cnt = 0;
        run_txn(4096, 8'hFF, -1, 0, -1);
        check("zero_share_ok", (z_cnt >= 901 && z_cnt <= 1147), 1);
        check("ones_share_ok", (o_cnt >= 901 && o_cnt <= 1147), 1);

        // Asynchronous reset mid-run, then the reset seed reproduces its sequence.
        op_mask = 8'hFF; num_trans = 16'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", valid_o, 0);
        check("arst_a", a_o, 0);
        check("arst_b", b_o, 0);
        check("arst_op", op_o, 0);
        check("arst_busy", busy, 0);
        check("arst_count", count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_seed(SEED);
        exp_q.delete();
        @(negedge clk);
        run_txn(4, 8'hFF, -1, 0, -1);

        // Pure-random 64-bit instance.
        nc_z = 0; nc_o = 0; ops_seen = '0; cyc = 0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        while (!done2 && cyc < 2000) begin
            if (valid2) begin
                if (a2 == 64'd0 || b2 == 64'd0) nc_z++;
                if (&a2 || &b2) nc_o++;
                ops_seen[op2] = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        check("nc_done", done2, 1);
        check("nc_count", count2, 1024);
        check("nc_busy", busy2, 0);
        check("nc_err", err2, 0);
        check("nc_zero_rare", nc_z < 10, 1);
        check("nc_ones_rare", nc_o < 10, 1);
        check("nc_all_ops", ops_seen, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
